// File: rtl/peripheral_bus_hub.sv
// Memory-mapped hub between the CPU data port and up to eight peripheral slots.
// Optional ACCESS watchdog is compiled in with `define PERIPHERAL_BUS_TIMEOUT_EN.
module peripheral_bus_hub #(
    parameter int NUM_SLOTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            readEnable,
    input  logic                            writeEnable,
    input  logic [30:0]                     address,
    input  logic [DATA_WIDTH-1:0]           dataIn,
    output logic [DATA_WIDTH-1:0]           dataOut,
    output logic                            ready,
    output logic                            busError,
    output logic [7:0]                      errorCount,
    output logic [NUM_SLOTS-1:0]            slotSel,
    output logic                            slotRead,
    output logic                            slotWrite,
    output logic [27:0]                     slotAddress,
    output logic [DATA_WIDTH-1:0]           slotDataOut,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slotDataIn,
    input  logic [NUM_SLOTS-1:0]            slotReady,
    output logic [1:0]                      fsm_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    // Handshake: the CPU holds readEnable/writeEnable until it sees ready=1
    // (a one-cycle pulse, qualified by busError); enables are sampled only in IDLE.
    // Toward a slot, slotRead/slotWrite stay high until that slot's slotReady is seen.

    logic [1:0]            state;
    logic                  write_q;
    logic [2:0]            slot_q;
    logic                  err_q;
    logic [2:0]            req_slot;
    logic                  req_mapped;
    logic                  slot_hit;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] slot_rdata;

    assign req_slot   = address[30:28];
    assign req_mapped = 32'(req_slot) < NUM_SLOTS;

    always_comb begin
        slotSel    = '0;
        slot_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotSel[i] = (state == S_ACCESS) && (32'(slot_q) == i);
            if (32'(slot_q) == i) begin
                slot_rdata = slotDataIn[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the selected slot's ready can complete the access.
    assign slot_hit = |(slotSel & slotReady);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != S_ACCESS) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // wait_cnt counts ACCESS cycles already completed; a slot ready in the last
    // allowed cycle still wins because slot_hit is checked first.
    assign timeout_hit = (state == S_ACCESS) && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            slot_q      <= '0;
            err_q       <= 1'b0;
            dataOut     <= '0;
            errorCount  <= '0;
            slotAddress <= '0;
            slotDataOut <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (readEnable || writeEnable) begin
                        write_q     <= writeEnable;
                        slot_q      <= req_slot;
                        slotAddress <= address[27:0];
                        slotDataOut <= dataIn;
                        if (req_mapped) begin
                            state <= S_ACCESS;
                        end else begin
                            state   <= S_RESPOND;
                            err_q   <= 1'b1;
                            dataOut <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (slot_hit) begin
                        state   <= S_RESPOND;
                        err_q   <= 1'b0;
                        dataOut <= write_q ? '0 : slot_rdata;
                    end else if (timeout_hit) begin
                        state   <= S_RESPOND;
                        err_q   <= 1'b1;
                        dataOut <= '0;
                    end
                end
                S_RESPOND: begin
                    state <= S_IDLE;
                    if (err_q && (errorCount != 8'hFF)) begin
                        errorCount <= errorCount + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready     = (state == S_RESPOND);
    assign busError  = (state == S_RESPOND) && err_q;
    assign slotRead  = (state == S_ACCESS) && !write_q;
    assign slotWrite = (state == S_ACCESS) && write_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_peripheral_bus_hub.sv
// Directed self-checking bench for peripheral_bus_hub (NUM_SLOTS=4, DATA_WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_peripheral_bus_hub;

    logic         clk;
    logic         reset;
    logic         readEnable;
    logic         writeEnable;
    logic [30:0]  address;
    logic [31:0]  dataIn;
    logic [31:0]  dataOut;
    logic         ready;
    logic         busError;
    logic [7:0]   errorCount;
    logic [3:0]   slotSel;
    logic         slotRead;
    logic         slotWrite;
    logic [27:0]  slotAddress;
    logic [31:0]  slotDataOut;
    logic [127:0] slotDataIn;
    logic [3:0]   slotReady;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;
    int exp_errs = 0;

    peripheral_bus_hub #(
        .NUM_SLOTS(4),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .readEnable(readEnable),
        .writeEnable(writeEnable),
        .address(address),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .ready(ready),
        .busError(busError),
        .errorCount(errorCount),
        .slotSel(slotSel),
        .slotRead(slotRead),
        .slotWrite(slotWrite),
        .slotAddress(slotAddress),
        .slotDataOut(slotDataOut),
        .slotDataIn(slotDataIn),
        .slotReady(slotReady),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        address     = '0;
        dataIn      = '0;
        slotReady   = '0;
        slotDataIn  = {32'h0000_0033, 32'h0000_0022, 32'h0000_00A5, 32'h0000_0011};

        // Reset state
        tick();
        tick();
        check("rst_dataOut", dataOut, 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_busError", 32'(busError), 32'h0);
        check("rst_errorCount", 32'(errorCount), 32'h0);
        check("rst_slotSel", 32'(slotSel), 32'h0);
        check("rst_strobes", 32'({slotRead, slotWrite}), 32'h0);
        check("rst_slotAddress", 32'(slotAddress), 32'h0);
        check("rst_slotDataOut", slotDataOut, 32'h0);
        reset = 1'b0;
        tick();

        // Zero-wait read of slot 1
        slotReady  = 4'b1111;
        readEnable = 1'b1;
        address    = 31'h1000_0000;
        tick();
        check("rd1_slotSel", 32'(slotSel), 32'h2);
        check("rd1_slotRead", 32'(slotRead), 32'h1);
        check("rd1_slotWrite", 32'(slotWrite), 32'h0);
        check("rd1_ready_early", 32'(ready), 32'h0);
        tick();
        check("rd1_ready", 32'(ready), 32'h1);
        check("rd1_busError", 32'(busError), 32'h0);
        check("rd1_dataOut", dataOut, 32'h0000_00A5);
        check("rd1_slotSel_off", 32'(slotSel), 32'h0);
        check("rd1_slotRead_off", 32'(slotRead), 32'h0);
        readEnable = 1'b0;
        tick();
        check("rd1_ready_pulse", 32'(ready), 32'h0);
        check("rd1_dataOut_hold", dataOut, 32'h0000_00A5);

        // Write to slot 0 with three wait states; other slots' ready must be ignored
        slotReady   = 4'b1110;
        writeEnable = 1'b1;
        address     = 31'h000_0004;
        dataIn      = 32'h0000_003F;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_wait_slotWrite", 32'(slotWrite), 32'h1);
            check("wr_wait_ready", 32'(ready), 32'h0);
            tick();
        end
        check("wr_slotSel", 32'(slotSel), 32'h1);
        check("wr_slotAddress", 32'(slotAddress), 32'h4);
        check("wr_slotDataOut", slotDataOut, 32'h0000_003F);
        check("wr_last_slotWrite", 32'(slotWrite), 32'h1);
        slotReady = 4'b0001;
        tick();
        check("wr_ready", 32'(ready), 32'h1);
        check("wr_busError", 32'(busError), 32'h0);
        check("wr_dataOut", dataOut, 32'h0);
        check("wr_slotWrite_off", 32'(slotWrite), 32'h0);
        writeEnable = 1'b0;
        slotReady   = 4'b0000;
        tick();

        // Unmapped slot 7
        readEnable = 1'b1;
        address    = 31'h7000_0000;
        tick();
        check("unm_ready", 32'(ready), 32'h1);
        check("unm_busError", 32'(busError), 32'h1);
        check("unm_strobes", 32'({slotRead, slotWrite}), 32'h0);
        check("unm_slotSel", 32'(slotSel), 32'h0);
        check("unm_dataOut", dataOut, 32'h0);
        readEnable = 1'b0;
        tick();
        exp_errs = 1;
        check("unm_errorCount", 32'(errorCount), 32'(exp_errs));
        check("unm_ready_off", 32'(ready), 32'h0);

        // Slot 2 never ready
        readEnable = 1'b1;
        address    = 31'h2000_0000;
        tick();
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            check("to_wait_slotRead", 32'(slotRead), 32'h1);
            tick();
        end
        check("to_ready", 32'(ready), 32'h1);
        check("to_busError", 32'(busError), 32'h1);
        check("to_slotRead_off", 32'(slotRead), 32'h0);
        check("to_slotSel_off", 32'(slotSel), 32'h0);
        check("to_dataOut", dataOut, 32'h0);
        readEnable = 1'b0;
        tick();
        exp_errs = 2;
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        check("nto_state", 32'(fsm_state), 32'h1);
        check("nto_slotRead", 32'(slotRead), 32'h1);
        check("nto_slotSel", 32'(slotSel), 32'h4);
        check("nto_ready", 32'(ready), 32'h0);
        slotReady = 4'b0100;
        tick();
        check("nto_late_ready", 32'(ready), 32'h1);
        check("nto_busError", 32'(busError), 32'h0);
        check("nto_dataOut", dataOut, 32'h0000_0022);
        readEnable = 1'b0;
        slotReady  = 4'b0000;
        tick();
`endif
        check("to_errorCount", 32'(errorCount), 32'(exp_errs));

        // Both enables high: write wins
        slotReady   = 4'b1000;
        readEnable  = 1'b1;
        writeEnable = 1'b1;
        address     = 31'h3000_0008;
        dataIn      = 32'h0000_0055;
        tick();
        check("both_slotWrite", 32'(slotWrite), 32'h1);
        check("both_slotRead", 32'(slotRead), 32'h0);
        check("both_slotSel", 32'(slotSel), 32'h8);
        check("both_slotDataOut", slotDataOut, 32'h0000_0055);
        tick();
        check("both_ready", 32'(ready), 32'h1);
        check("both_dataOut", dataOut, 32'h0);
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        slotReady   = 4'b0000;
        tick();

        // Back-to-back unmapped accesses with the enable held: one response per two cycles
        readEnable = 1'b1;
        address    = 31'h5000_0000;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_mid_errorCount", 32'(errorCount), 32'(exp_errs + 10));
        for (int i = 0; i < 600; i++) begin
            tick();
        end
        readEnable = 1'b0;
        tick();
        check("sat_errorCount", 32'(errorCount), 32'd255);
        check("sat_ready_off", 32'(ready), 32'h0);

        // Reset during a wait-stated read
        slotReady  = 4'b0000;
        readEnable = 1'b1;
        address    = 31'h1000_0000;
        tick();
        tick();
        check("mid_slotRead", 32'(slotRead), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_slotRead", 32'(slotRead), 32'h0);
        check("mid_rst_slotSel", 32'(slotSel), 32'h0);
        check("mid_rst_errorCount", 32'(errorCount), 32'h0);
        readEnable = 1'b0;
        tick();
        check("mid_rst_ready", 32'(ready), 32'h0);
        reset = 1'b0;
        tick();
        check("mid_post_ready", 32'(ready), 32'h0);
        check("mid_post_slotSel", 32'(slotSel), 32'h0);
        slotReady  = 4'b0010;
        readEnable = 1'b1;
        address    = 31'h1000_0000;
        tick();
        check("mid_rd_slotSel", 32'(slotSel), 32'h2);
        tick();
        check("mid_rd_ready", 32'(ready), 32'h1);
        check("mid_rd_dataOut", dataOut, 32'h0000_00A5);
        check("mid_rd_busError", 32'(busError), 32'h0);
        readEnable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
